// File: rtl/sb_spi_pkg.sv
// sb_spi_pkg: shared definitions for the SB SPI slave.
//   - register offsets within the block (sbadri[3:0])
//   - SPISR bit positions and SPICR1/SPICR2 control bit positions
//   - a status struct and the helper that packs it into the SPISR byte
package sb_spi_pkg;

    localparam logic [3:0] OFF_SPICR0  = 4'h8;
    localparam logic [3:0] OFF_SPICR1  = 4'h9;
    localparam logic [3:0] OFF_SPICR2  = 4'hA;
    localparam logic [3:0] OFF_SPIBR   = 4'hB;
    localparam logic [3:0] OFF_SPISR   = 4'hC;
    localparam logic [3:0] OFF_SPITXDR = 4'hD;
    localparam logic [3:0] OFF_SPIRXDR = 4'hE;
    localparam logic [3:0] OFF_SPICSR  = 4'hF;

    localparam int SR_TIP  = 7;
    localparam int SR_BUSY = 6;
    localparam int SR_TOE  = 5;
    localparam int SR_TRDY = 4;
    localparam int SR_RRDY = 3;
    localparam int SR_ROE  = 2;

    localparam int CR1_SPE  = 7;
    localparam int CR2_MSTR = 7;
    localparam int CR2_CPOL = 2;
    localparam int CR2_CPHA = 1;
    localparam int CR2_LSBF = 0;

    typedef struct packed {
        logic tip;
        logic busy;
        logic toe;
        logic trdy;
        logic rrdy;
        logic roe;
    } spi_status_t;

    function automatic logic [7:0] pack_spisr(input spi_status_t s);
        logic [7:0] r;
        r          = 8'h00;
        r[SR_TIP]  = s.tip;
        r[SR_BUSY] = s.busy;
        r[SR_TOE]  = s.toe;
        r[SR_TRDY] = s.trdy;
        r[SR_RRDY] = s.rrdy;
        r[SR_ROE]  = s.roe;
        return r;
    endfunction

endpackage

// File: rtl/spi_slave_shifter.sv
// spi_slave_shifter: SPI slave datapath in the clk domain.
//   Synchronises scki/scsni/si (2 flops each), detects scki edges, and runs
//   the transmit/receive shift registers and the bit counter.
// Ports:
//   clk, rst            system clock, async active-high reset
//   scki, scsni, si     raw SPI inputs from the external master
//   spe, cpol, cpha, lsbf  configuration from the register file
//   load_data           byte to transmit next (chosen by the register file)
//   load                pulse: load_data is taken into the shift register
//   rx_done, rx_byte    pulse + byte after the 8th sample of a byte
//   tip                 a byte is in progress
//   active              enabled and selected
//   so                  MISO, 0 whenever not active
module spi_slave_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       scki,
    input  logic       scsni,
    input  logic       si,
    input  logic       spe,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       lsbf,
    input  logic [7:0] load_data,
    output logic       load,
    output logic       rx_done,
    output logic [7:0] rx_byte,
    output logic       tip,
    output logic       active,
    output logic       so
);

    logic sck_meta, sck_sync, sck_prev;
    logic csn_meta, csn_sync, csn_prev;
    logic si_meta, si_sync;

    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic [2:0] bit_cnt;
    // shift_pending: a sample happened since the last load/shift, so the next
    // shift edge may advance tx_sr. This keeps the freshly loaded first bit on
    // so through the leading edge in CPHA=1.
    logic       shift_pending;
    // trail: in CPHA=0 the byte ends on a leading edge; the trailing edge that
    // follows still belongs to the finished byte and must not raise TIP.
    logic       trail;

    logic sck_eff, sck_eff_prev, lead_edge, trail_edge;
    logic sample_edge, shift_edge, cs_fall, last_sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_meta <= 1'b0;
            sck_sync <= 1'b0;
            sck_prev <= 1'b0;
            csn_meta <= 1'b1;
            csn_sync <= 1'b1;
            csn_prev <= 1'b1;
            si_meta  <= 1'b0;
            si_sync  <= 1'b0;
        end else begin
            sck_meta <= scki;
            sck_sync <= sck_meta;
            sck_prev <= sck_sync;
            csn_meta <= scsni;
            csn_sync <= csn_meta;
            csn_prev <= csn_sync;
            si_meta  <= si;
            si_sync  <= si_meta;
        end
    end

    assign active       = spe & ~csn_sync;
    // CPOL=1 is handled by inverting scki: "leading" is always idle->active.
    assign sck_eff      = sck_sync ^ cpol;
    assign sck_eff_prev = sck_prev ^ cpol;
    assign lead_edge    = active & sck_eff & ~sck_eff_prev;
    assign trail_edge   = active & ~sck_eff & sck_eff_prev;
    assign sample_edge  = cpha ? trail_edge : lead_edge;
    assign shift_edge   = cpha ? lead_edge : trail_edge;
    assign cs_fall      = spe & csn_prev & ~csn_sync;
    assign last_sample  = sample_edge & (bit_cnt == 3'd7);
    assign load         = cs_fall | last_sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr         <= 8'h00;
            rx_sr         <= 8'h00;
            bit_cnt       <= 3'd0;
            shift_pending <= 1'b0;
            trail         <= 1'b0;
            tip           <= 1'b0;
            rx_done       <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (!active) begin
                // Deselect (or disable) aborts any partial byte.
                bit_cnt       <= 3'd0;
                shift_pending <= 1'b0;
                trail         <= 1'b0;
                tip           <= 1'b0;
            end else begin
                if (load) begin
                    tx_sr         <= load_data;
                    shift_pending <= 1'b0;
                end else if (shift_edge && shift_pending) begin
                    tx_sr         <= lsbf ? {1'b0, tx_sr[7:1]} : {tx_sr[6:0], 1'b0};
                    shift_pending <= 1'b0;
                end

                if (sample_edge) begin
                    rx_sr   <= lsbf ? {si_sync, rx_sr[7:1]} : {rx_sr[6:0], si_sync};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_done <= 1'b1;
                        tip     <= 1'b0;
                        trail   <= ~cpha;
                    end else begin
                        shift_pending <= 1'b1;
                        tip           <= 1'b1;
                    end
                end else if (shift_edge) begin
                    if (trail) begin
                        trail <= 1'b0;
                    end else begin
                        tip <= 1'b1;
                    end
                end
            end
        end
    end

    assign rx_byte = rx_sr;
    assign so      = active ? (lsbf ? tx_sr[0] : tx_sr[7]) : 1'b0;

endmodule

// File: rtl/sb_spi_slave.sv
// sb_spi_slave: SPI slave with a system-bus register file.
// Ports:
//   clk, rst                 system clock, async active-high reset
//   sbrwi, sbstbi            bus direction (1 = write) and strobe
//   sbadri, sbdati, sbdato   bus address, write data, read data
//   sbacko                   one-cycle acknowledge
//   scki, scsni, si, so      SPI clock, select (active-low), MOSI, MISO
// Bus handshake: the master raises sbstbi with address/data and holds them
// until it sees sbacko. An access is taken on the edge where sbstbi=1, the
// upper address nibble matches and sbacko=0; sbacko is high for the following
// cycle only, so a strobe still high during that cycle is not a new access.
// sbdato is updated by read accesses and holds until the next read.
module sb_spi_slave #(
    parameter logic [3:0] BUS_ADDR74 = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sbrwi,
    input  logic       sbstbi,
    input  logic [7:0] sbadri,
    input  logic [7:0] sbdati,
    output logic [7:0] sbdato,
    output logic       sbacko,
    input  logic       scki,
    input  logic       scsni,
    input  logic       si,
    output logic       so
);
    import sb_spi_pkg::*;

    logic [7:0] cr0, cr1, cr2, br, csr, txdr, rxdr;
    logic       toe, trdy, rrdy, roe;

    logic       hit, wr_hit, rd_hit;
    logic [7:0] rdata;
    logic [7:0] load_data;
    logic       sh_load, sh_rx_done, sh_tip, sh_active;
    logic [7:0] sh_rx_byte;
    spi_status_t status;

    assign hit    = sbstbi & (sbadri[7:4] == BUS_ADDR74) & ~sbacko;
    assign wr_hit = hit & sbrwi;
    assign rd_hit = hit & ~sbrwi;

    // Pending TXDR is sent once; with nothing pending the slave sends 0xFF.
    assign load_data = trdy ? 8'hFF : txdr;

    spi_slave_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .scki      (scki),
        .scsni     (scsni),
        .si        (si),
        .spe       (cr1[CR1_SPE]),
        .cpol      (cr2[CR2_CPOL]),
        .cpha      (cr2[CR2_CPHA]),
        .lsbf      (cr2[CR2_LSBF]),
        .load_data (load_data),
        .load      (sh_load),
        .rx_done   (sh_rx_done),
        .rx_byte   (sh_rx_byte),
        .tip       (sh_tip),
        .active    (sh_active),
        .so        (so)
    );

    assign status = '{tip: sh_tip, busy: sh_active, toe: toe, trdy: trdy, rrdy: rrdy, roe: roe};

    always_comb begin
        rdata = 8'h00;
        case (sbadri[3:0])
            OFF_SPICR0:  rdata = cr0;
            OFF_SPICR1:  rdata = cr1;
            OFF_SPICR2:  rdata = cr2;
            OFF_SPIBR:   rdata = br;
            OFF_SPISR:   rdata = pack_spisr(status);
            OFF_SPITXDR: rdata = txdr;
            OFF_SPIRXDR: rdata = rxdr;
            OFF_SPICSR:  rdata = csr;
            default:     rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbacko <= 1'b0;
            sbdato <= 8'h00;
        end else begin
            sbacko <= hit;
            if (rd_hit) begin
                sbdato <= rdata;
            end
        end
    end

    // Bus side effects first; SPI events later in the block so an SPI set
    // overrides a bus clear of the same flag in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cr0  <= 8'h00;
            cr1  <= 8'h00;
            cr2  <= 8'h00;
            br   <= 8'h00;
            csr  <= 8'h00;
            txdr <= 8'h00;
            rxdr <= 8'h00;
            toe  <= 1'b0;
            trdy <= 1'b1;
            rrdy <= 1'b0;
            roe  <= 1'b0;
        end else begin
            if (wr_hit) begin
                case (sbadri[3:0])
                    OFF_SPICR0:  cr0 <= sbdati;
                    OFF_SPICR1:  cr1 <= sbdati;
                    OFF_SPICR2:  cr2 <= sbdati;
                    OFF_SPIBR:   br  <= sbdati;
                    OFF_SPICSR:  csr <= sbdati;
                    OFF_SPITXDR: begin
                        txdr <= sbdati;
                        trdy <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (rd_hit && sbadri[3:0] == OFF_SPISR) begin
                toe <= 1'b0;
                roe <= 1'b0;
            end
            if (rd_hit && sbadri[3:0] == OFF_SPIRXDR) begin
                rrdy <= 1'b0;
            end
            if (sh_load) begin
                if (!trdy) begin
                    trdy <= 1'b1;
                end else begin
                    toe <= 1'b1;
                end
            end
            if (sh_rx_done) begin
                rxdr <= sh_rx_byte;
                rrdy <= 1'b1;
                if (rrdy) begin
                    roe <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sb_spi_slave.sv
// tb_sb_spi_slave: self-checking bench for sb_spi_slave.
// A behavioural model (register values, flags, byte queue of what the slave
// will transmit) predicts every bus read and every byte the master receives.
module tb_sb_spi_slave;

    localparam int H = 6;   // clk cycles per half scki period

    logic       clk = 1'b0;
    logic       rst;
    logic       sbrwi, sbstbi;
    logic [7:0] sbadri, sbdati, sbdato;
    logic       sbacko;
    logic       scki, scsni, si, so;

    always #5 clk = ~clk;

    sb_spi_slave #(.BUS_ADDR74(4'b0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .sbrwi  (sbrwi),
        .sbstbi (sbstbi),
        .sbadri (sbadri),
        .sbdati (sbdati),
        .sbdato (sbdato),
        .sbacko (sbacko),
        .scki   (scki),
        .scsni  (scsni),
        .si     (si),
        .so     (so)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int ack_cnt = 0;
    int csn_hi_cnt = 0;
    logic [8:0] exp_q[$];   // {is_read, expected sbdato}

    // ---------------- model ----------------
    logic [7:0] m_cr0, m_cr1, m_cr2, m_br, m_csr, m_txdr, m_rxdr, m_shift;
    bit         m_trdy, m_rrdy, m_toe, m_roe;
    bit         cpol_cur, cpha_cur, lsbf_cur;

    function automatic void m_reset();
        m_cr0 = 0; m_cr1 = 0; m_cr2 = 0; m_br = 0; m_csr = 0;
        m_txdr = 0; m_rxdr = 0; m_shift = 0;
        m_trdy = 1; m_rrdy = 0; m_toe = 0; m_roe = 0;
    endfunction

    function automatic void m_load();
        if (!m_trdy) begin
            m_shift = m_txdr;
            m_trdy  = 1;
        end else begin
            m_shift = 8'hFF;
            m_toe   = 1;
        end
    endfunction

    function automatic void m_rx(input logic [7:0] b);
        if (m_rrdy) m_roe = 1;
        m_rxdr = b;
        m_rrdy = 1;
    endfunction

    function automatic void m_write(input logic [7:0] a, input logic [7:0] d);
        if (a[7:4] == 4'h0) begin
            case (a[3:0])
                4'h8: m_cr0 = d;
                4'h9: m_cr1 = d;
                4'hA: m_cr2 = d;
                4'hB: m_br  = d;
                4'hD: begin m_txdr = d; m_trdy = 0; end
                4'hF: m_csr = d;
                default: ;
            endcase
        end
    endfunction

    // Reads happen only while deselected, so TIP and BUSY are 0.
    function automatic logic [7:0] m_read(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h00;
        case (a[3:0])
            4'h8: v = m_cr0;
            4'h9: v = m_cr1;
            4'hA: v = m_cr2;
            4'hB: v = m_br;
            4'hC: begin
                v = {2'b00, m_toe, m_trdy, m_rrdy, m_roe, 2'b00};
                m_toe = 0;
                m_roe = 0;
            end
            4'hD: v = m_txdr;
            4'hE: begin v = m_rxdr; m_rrdy = 0; end
            4'hF: v = m_csr;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (scsni) csn_hi_cnt++; else csn_hi_cnt = 0;
        if (!rst) begin
            if (sbacko) begin
                ack_cnt++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got sbacko=1 addr=0x%0h, expected 0", sbadri);
                end else begin
                    e = exp_q.pop_front();
                    if (e[8]) chk("sbdato", {24'h0, sbdato}, {24'h0, e[7:0]});
                end
            end
            if (csn_hi_cnt >= 4) chk("so_idle", {31'h0, so}, 32'h0);
        end
    end

    // ---------------- bus driver ----------------
    task automatic bus_xfer(input logic rw, input logic [7:0] addr, input logic [7:0] wd,
                            input bit expect_ack, input int hold);
        int a0;
        @(negedge clk);
        sbrwi = rw; sbadri = addr; sbdati = wd; sbstbi = 1'b1;
        a0 = ack_cnt;
        repeat (hold) @(negedge clk);
        sbstbi = 1'b0;
        repeat (3) @(negedge clk);
        chk("ack_count", ack_cnt - a0, expect_ack ? 1 : 0);
        exp_q.delete();
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        m_write(a, d);
        exp_q.push_back(9'h000);
        bus_xfer(1'b1, a, d, 1, 2);
    endtask

    task automatic bus_read(input logic [7:0] a, input bit use_lit, input logic [7:0] lit);
        logic [7:0] m;
        m = m_read(a);
        if (use_lit) chk("model_pin", {24'h0, m}, {24'h0, lit});
        exp_q.push_back({1'b1, m});
        bus_xfer(1'b0, a, 8'h00, 1, 2);
    endtask

    // ---------------- SPI master driver ----------------
    task automatic set_mode(input bit cp, input bit ch, input bit lf);
        logic [4:0] r;
        r = 5'($urandom_range(0, 31));
        bus_write(8'h0A, {r, cp, ch, lf});
        cpol_cur = cp; cpha_cur = ch; lsbf_cur = lf;
        scki = cp;
        repeat (H) @(negedge clk);
    endtask

    task automatic frame_start();
        @(negedge clk);
        scki  = cpol_cur;
        scsni = 1'b0;
        repeat (H) @(negedge clk);
        m_load();
    endtask

    task automatic frame_end();
        scki  = cpol_cur;
        scsni = 1'b1;
        repeat (2 * H) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        int idx;
        miso = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            idx = lsbf_cur ? i : 7 - i;
            if (!cpha_cur) begin
                si = mosi[idx];
                repeat (H) @(negedge clk);
                miso[idx] = so;
                scki = ~cpol_cur;
                repeat (H) @(negedge clk);
                scki = cpol_cur;
            end else begin
                scki = ~cpol_cur;
                si = mosi[idx];
                repeat (H) @(negedge clk);
                miso[idx] = so;
                scki = cpol_cur;
                repeat (H) @(negedge clk);
            end
        end
        repeat (H) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] mosi);
        logic [7:0] miso;
        spi_bits(mosi, 8, miso);
        chk("miso", {24'h0, miso}, {24'h0, m_shift});
        m_rx(mosi);
        m_load();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] junk;
        rst = 1'b1; sbrwi = 0; sbstbi = 0; sbadri = 0; sbdati = 0;
        scki = 0; scsni = 1; si = 0;
        cpol_cur = 0; cpha_cur = 0; lsbf_cur = 0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_sbacko", {31'h0, sbacko}, 0);
        chk("rst_sbdato", {24'h0, sbdato}, 0);
        chk("rst_so", {31'h0, so}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values of every register
        bus_read(8'h08, 1, 8'h00);
        bus_read(8'h09, 1, 8'h00);
        bus_read(8'h0A, 1, 8'h00);
        bus_read(8'h0B, 1, 8'h00);
        bus_read(8'h0C, 1, 8'h10);
        bus_read(8'h0D, 1, 8'h00);
        bus_read(8'h0E, 1, 8'h00);
        bus_read(8'h0F, 1, 8'h00);

        // SPE write / readback; unmapped low addresses
        bus_write(8'h09, 8'h80);
        bus_read(8'h09, 1, 8'h80);
        bus_write(8'h05, 8'h77);
        bus_read(8'h05, 1, 8'h00);

        // Wrong upper nibble: no ack over 10 cycles
        bus_xfer(1'b0, 8'h18, 8'h00, 0, 10);

        // Mode 0: TXDR=A5, master sends 3C
        set_mode(0, 0, 0);
        bus_write(8'h0D, 8'hA5);
        frame_start();
        chk("model_miso_a5", {24'h0, m_shift}, 32'hA5);
        spi_byte(8'h3C);
        frame_end();
        bus_read(8'h0C, 1, 8'h38);
        bus_read(8'h0E, 1, 8'h3C);
        bus_read(8'h0C, 1, 8'h10);

        // Two bytes, nothing queued, nothing read: underrun + overrun
        frame_start();
        chk("model_miso_ff", {24'h0, m_shift}, 32'hFF);
        spi_byte(8'hC3);
        spi_byte(8'h5A);
        frame_end();
        bus_read(8'h0C, 1, 8'h3C);
        bus_read(8'h0C, 1, 8'h18);
        bus_read(8'h0E, 1, 8'h5A);

        // LSB first: TXDR=01 puts a 1 on so right after select
        set_mode(0, 0, 1);
        bus_write(8'h0D, 8'h01);
        frame_start();
        chk("lsbf_first_bit", {31'h0, so}, 1);
        spi_byte(8'h96);
        frame_end();
        bus_read(8'h0E, 1, 8'h96);

        // Partial byte aborted by deselect, then a full byte
        set_mode(0, 0, 0);
        frame_start();
        spi_bits(8'hF0, 3, junk);
        frame_end();
        frame_start();
        spi_byte(8'h81);
        frame_end();
        bus_read(8'h0E, 1, 8'h81);
        bus_read(8'h0C, 0, 8'h00);

        // Randomised frames over all modes
        for (int it = 0; it < 24; it++) begin
            int nb;
            set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1)) bus_write(8'h0D, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) bus_write(8'h08, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) bus_write(8'h0B, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) bus_write(8'h0F, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) bus_write(8'h09, 8'h80 | 8'($urandom_range(0, 127)));
            nb = $urandom_range(1, 2);
            frame_start();
            for (int b = 0; b < nb; b++) spi_byte(8'($urandom_range(0, 255)));
            frame_end();
            if ($urandom_range(0, 1)) bus_read(8'h0C, 0, 8'h00);
            if ($urandom_range(0, 1)) bus_read(8'h0E, 0, 8'h00);
            bus_read(8'($urandom_range(8, 15)), 0, 8'h00);
        end

        // Reset mid-byte, then a clean byte
        set_mode(0, 0, 0);
        frame_start();
        spi_bits(8'hAA, 4, junk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        m_reset();
        scki = 0; scsni = 1; si = 0;
        cpol_cur = 0; cpha_cur = 0; lsbf_cur = 0;
        rst = 1'b0;
        repeat (H) @(negedge clk);
        bus_read(8'h0C, 1, 8'h10);
        bus_read(8'h0E, 1, 8'h00);
        bus_write(8'h09, 8'h80);
        set_mode(0, 0, 0);
        frame_start();
        spi_byte(8'h55);
        frame_end();
        bus_read(8'h0E, 1, 8'h55);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sb_spi_slave.md
SB_SPI_SLAVE -- requirements
Module: sb_spi_slave

Interface
REQ-001 SHALL have parameter BUS_ADDR74, default 4'b0000: the value sbadri[7:4] must equal for the block to respond.
REQ-002 SHALL have port clk, input, 1 bit: system clock; one clock, all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port sbrwi, input, 1 bit: 1 = write, 0 = read.
REQ-005 SHALL have port sbstbi, input, 1 bit: bus strobe, held high until ack is seen.
REQ-006 SHALL have port sbadri, input, 8 bits: register address.
REQ-007 SHALL have port sbdati, input, 8 bits: write data.
REQ-008 SHALL have port sbdato, output, 8 bits: read data.
REQ-009 SHALL have port sbacko, output, 1 bit: one-cycle acknowledge.
REQ-010 SHALL have port scki, input, 1 bit: SPI clock from the external master.
REQ-011 SHALL have port scsni, input, 1 bit: SPI slave select, active-low.
REQ-012 SHALL have port si, input, 1 bit: MOSI.
REQ-013 SHALL have port so, output, 1 bit: MISO.

Function
REQ-014 SHALL map registers at sbadri[3:0]: 8 SPICR0, 9 SPICR1, A SPICR2, B SPIBR, C SPISR, D SPITXDR, E SPIRXDR, F SPICSR. Addresses 0-7 read 0x00 and ignore writes.
REQ-015 SHALL, when sbstbi=1, sbadri[7:4]=BUS_ADDR74 and sbacko=0 at a clock edge, set sbacko=1 for exactly one cycle; the access completes on that same edge.
REQ-016 SHALL never acknowledge when sbadri[7:4] does not equal BUS_ADDR74.
REQ-017 SHALL keep sbdato valid while sbacko=1 and hold it until the next access.
REQ-018 SHALL perform a strobe still high in the cycle after ack as neither a second access nor a second ack.
REQ-019 SHALL treat SPICR0, SPIBR and SPICSR as plain read/write storage.
REQ-020 SHALL treat SPICR1 bit7 as SPE, the enable; other SPICR1 bits are storage.
REQ-021 SHALL treat SPICR2 bits as: bit7 MSTR (stored, ignored; slave only), bit2 CPOL, bit1 CPHA, bit0 LSBF; other bits are storage.
REQ-022 SHALL read SPISR as: bit7 TIP, bit6 BUSY, bit5 TOE, bit4 TRDY, bit3 RRDY, bit2 ROE; other bits 0.
REQ-023 SHALL clear TOE and ROE on a SPISR read ack.
REQ-024 SHALL treat a write to SPITXDR as: store the byte, clear TRDY.
REQ-025 SHALL treat a read of SPIRXDR as: return the byte, clear RRDY.
REQ-026 SHALL synchronise scki, scsni and si with 2-flop synchronisers and detect scki edges in the clk domain; clk is at least 4x scki.
REQ-027 SHALL apply SPI rules only when SPE=1 and scsni=0; otherwise ignore scki and drive so=0.
REQ-028 SHALL keep BUSY=1 while selected.
REQ-029 SHALL keep TIP=1 from the first scki edge of a byte until its 8th sample.
REQ-030 SHALL load the shift register on scsni falling and after every 8th bit: TXDR if TRDY=0 (then set TRDY=1); otherwise 0xFF and set TOE.
REQ-031 SHALL run mode 0 (CPOL=0, CPHA=0) as: present the first bit on so at load, sample si on rising scki, shift on falling scki.
REQ-032 SHALL use the opposite edges for CPHA=1 and invert scki when CPOL=1.
REQ-033 SHALL send MSB first unless LSBF=1.
REQ-034 SHALL, after the 8th sample, copy the received byte to RXDR and set RRDY; if RRDY was already 1, overwrite RXDR and set ROE.
REQ-035 SHALL abort a partial byte when scsni rises: reset the bit count, keep RXDR unchanged, drive so=0.
REQ-036 SHALL, when a bus event and an SPI event hit the same flag in one cycle, let the SPI set win over the bus clear.

Reset
REQ-037 SHALL, on rst=1, set all registers to 0x00, except TRDY=1.
REQ-038 SHALL, on rst=1, drive sbacko=0, sbdato=0x00 and so=0, reset the shift register and bit count, and set the synchronisers to idle (scsni=1).
REQ-039 SHALL, when reset hits mid-byte, discard that byte with no RRDY.

Structure
REQ-040 SHALL put register offsets and SPISR bit indices in shared package sb_spi_pkg.
REQ-041 SHALL use one sub-module, spi_slave_shifter: synchronisers, edge detect, shift register and bit counter.
REQ-042 SHALL keep the bus register file in the top module.

Verification
REQ-043 SHALL cover: write SPICR1=0x80 at address 0x09, read it back -> sbdato=0x80, exactly one sbacko pulse per access, strobe high for 2 cycles.
REQ-044 SHALL cover: sbadri=0x18 with BUS_ADDR74=0 -> no ack for 10 cycles.
REQ-045 SHALL cover: SPE=1, mode 0, TXDR=0xA5, master shifts 0x3C -> master receives 0xA5, RXDR=0x3C, RRDY=1, TRDY=1; reading 0x0E gives 0x3C and clears RRDY.
REQ-046 SHALL cover: two master bytes with no TXDR write and no RXDR read -> master gets 0xFF; TOE=1 and ROE=1 in SPISR; a second SPISR read shows both 0.
REQ-047 SHALL cover: LSBF=1, TXDR=0x01 -> first bit on so is 1.
REQ-048 SHALL cover: rst asserted after 4 bits, then a full byte 0x55 -> RXDR=0x55 with no corruption.
